// File: rtl/umi_pack_unpack.sv
// -----------------------------------------------------------------------------
// umi_pack_unpack
//
// Bit-exact encoder/decoder for the 256-bit UMI transaction packet. The pack
// path builds a packet from individual header fields (or passes a raw burst
// beat straight through). The unpack path splits a packet back into its
// fields. The two paths share nothing and may change in the same cycle.
// There is no handshake here; valid/ready belong to the instantiating adapter.
//
// Build option:
//   UMI_PACK_REG_EN  defined   -> every output is registered on rising clk
//                                 (1-cycle latency, full throughput) and
//                                 cleared asynchronously while nreset is low.
//                    undefined -> purely combinational; clk/nreset unused.
//
// Ports:
//   clk, nreset       clock and asynchronous active-low reset
//   write, command    pack: opcode byte = {command, write}
//   size, options     pack: log2(bytes) and user/option field
//   burst             pack: 1 = raw data beat, header inputs ignored
//   dstaddr, srcaddr  pack: 64-bit destination / source addresses
//   data              pack: payload (only [95:0] is carried in a header packet)
//   packet_out        packed 256-bit packet
//   packet_in         unpack: 256-bit packet, always decoded as a header
//   unp_*             decoded fields; unp_data is zero-extended to 256 bits
// -----------------------------------------------------------------------------
module umi_pack_unpack (
  input  logic         clk,
  input  logic         nreset,
  input  logic         write,
  input  logic [6:0]   command,
  input  logic [3:0]   size,
  input  logic [19:0]  options,
  input  logic         burst,
  input  logic [63:0]  dstaddr,
  input  logic [63:0]  srcaddr,
  input  logic [255:0] data,
  output logic [255:0] packet_out,
  input  logic [255:0] packet_in,
  output logic         unp_write,
  output logic [6:0]   unp_command,
  output logic [3:0]   unp_size,
  output logic [19:0]  unp_options,
  output logic [63:0]  unp_dstaddr,
  output logic [63:0]  unp_srcaddr,
  output logic [255:0] unp_data
);

  logic [255:0] pack_c;
  logic         unp_write_c;
  logic [6:0]   unp_command_c;
  logic [3:0]   unp_size_c;
  logic [19:0]  unp_options_c;
  logic [63:0]  unp_dstaddr_c;
  logic [63:0]  unp_srcaddr_c;
  logic [255:0] unp_data_c;

  // Pack: a burst beat is the raw payload; otherwise lay the fields out in
  // the header format. The low halves of the addresses sit in the first
  // 96 bits so a 32-bit-address consumer only ever needs the bottom of the
  // packet; the high halves live at the top above the 96-bit payload.
  always_comb begin
    pack_c = '0;
    if (burst) begin
      pack_c = data;
    end else begin
      pack_c[0]       = write;
      pack_c[7:1]     = command;
      pack_c[11:8]    = size;
      pack_c[31:12]   = options;
      pack_c[63:32]   = dstaddr[31:0];
      pack_c[95:64]   = srcaddr[31:0];
      pack_c[191:96]  = data[95:0];
      pack_c[223:192] = srcaddr[63:32];
      pack_c[255:224] = dstaddr[63:32];
    end
  end

  // Unpack: always interpreted as a header. Burst beats are consumed by the
  // adapter straight from packet_in, so no burst decode is needed here, and
  // opcodes are passed through without any legality checking.
  always_comb begin
    unp_write_c   = packet_in[0];
    unp_command_c = packet_in[7:1];
    unp_size_c    = packet_in[11:8];
    unp_options_c = packet_in[31:12];
    unp_dstaddr_c = {packet_in[255:224], packet_in[63:32]};
    unp_srcaddr_c = {packet_in[223:192], packet_in[95:64]};
    unp_data_c    = {160'b0, packet_in[191:96]};
  end

`ifdef UMI_PACK_REG_EN
  // Optional output pipeline stage: one register per output, cleared
  // asynchronously so a downstream adapter sees an all-zero (opcode 0x00)
  // packet the moment reset asserts.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      packet_out  <= '0;
      unp_write   <= 1'b0;
      unp_command <= '0;
      unp_size    <= '0;
      unp_options <= '0;
      unp_dstaddr <= '0;
      unp_srcaddr <= '0;
      unp_data    <= '0;
    end else begin
      packet_out  <= pack_c;
      unp_write   <= unp_write_c;
      unp_command <= unp_command_c;
      unp_size    <= unp_size_c;
      unp_options <= unp_options_c;
      unp_dstaddr <= unp_dstaddr_c;
      unp_srcaddr <= unp_srcaddr_c;
      unp_data    <= unp_data_c;
    end
  end
`else
  // Combinational build: outputs follow the inputs directly. clk and nreset
  // are kept on the port list so both builds share one footprint.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ nreset;

  assign packet_out  = pack_c;
  assign unp_write   = unp_write_c;
  assign unp_command = unp_command_c;
  assign unp_size    = unp_size_c;
  assign unp_options = unp_options_c;
  assign unp_dstaddr = unp_dstaddr_c;
  assign unp_srcaddr = unp_srcaddr_c;
  assign unp_data    = unp_data_c;
`endif

endmodule

// File: tb/tb_umi_pack_unpack.sv
// -----------------------------------------------------------------------------
// tb_umi_pack_unpack
//
// Self-checking bench for umi_pack_unpack. Inputs change on the falling clock
// edge; outputs are sampled 1 time unit after the following rising edge, which
// suits both the combinational and the UMI_PACK_REG_EN build. Expected
// results are queued when stimulus is driven and popped when sampled.
// -----------------------------------------------------------------------------
module tb_umi_pack_unpack;

  typedef struct packed {
    logic         w;
    logic [6:0]   cmd;
    logic [3:0]   sz;
    logic [19:0]  opt;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [255:0] dat;
  } unp_t;

  logic         clk = 1'b0;
  logic         nreset;
  logic         write;
  logic [6:0]   command;
  logic [3:0]   size;
  logic [19:0]  options;
  logic         burst;
  logic [63:0]  dstaddr;
  logic [63:0]  srcaddr;
  logic [255:0] data;
  logic [255:0] packet_out;
  logic [255:0] packet_in;
  logic         unp_write;
  logic [6:0]   unp_command;
  logic [3:0]   unp_size;
  logic [19:0]  unp_options;
  logic [63:0]  unp_dstaddr;
  logic [63:0]  unp_srcaddr;
  logic [255:0] unp_data;

  int checks = 0;
  int errors = 0;

  logic [255:0] pack_q[$];
  unp_t         unp_q[$];

  umi_pack_unpack dut (
    .clk        (clk),
    .nreset     (nreset),
    .write      (write),
    .command    (command),
    .size       (size),
    .options    (options),
    .burst      (burst),
    .dstaddr    (dstaddr),
    .srcaddr    (srcaddr),
    .data       (data),
    .packet_out (packet_out),
    .packet_in  (packet_in),
    .unp_write  (unp_write),
    .unp_command(unp_command),
    .unp_size   (unp_size),
    .unp_options(unp_options),
    .unp_dstaddr(unp_dstaddr),
    .unp_srcaddr(unp_srcaddr),
    .unp_data   (unp_data)
  );

  always #5 clk = ~clk;

  // Reference header layout, written field by field.
  function automatic logic [255:0] model_pack(input logic w, input logic [6:0] cmd,
                                              input logic [3:0] sz, input logic [19:0] opt,
                                              input logic [63:0] dst, input logic [63:0] src,
                                              input logic [95:0] dat);
    logic [255:0] p;
    p          = '0;
    p[7:0]     = {cmd, w};
    p[11:8]    = sz;
    p[31:12]   = opt;
    p[63:32]   = dst[31:0];
    p[95:64]   = src[31:0];
    p[191:96]  = dat;
    p[223:192] = src[63:32];
    p[255:224] = dst[63:32];
    return p;
  endfunction

  function automatic unp_t model_unpack(input logic [255:0] p);
    unp_t u;
    u.w   = p[0];
    u.cmd = p[7:1];
    u.sz  = p[11:8];
    u.opt = p[31:12];
    u.dst = {p[255:224], p[63:32]};
    u.src = {p[223:192], p[95:64]};
    u.dat = {160'b0, p[191:96]};
    return u;
  endfunction

  function automatic unp_t dut_unp();
    return {unp_write, unp_command, unp_size, unp_options, unp_dstaddr, unp_srcaddr, unp_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fields(input logic w, input logic [6:0] cmd, input logic [3:0] sz,
                              input logic [19:0] opt, input logic b, input logic [63:0] dst,
                              input logic [63:0] src, input logic [255:0] dat);
    write   = w;
    command = cmd;
    size    = sz;
    options = opt;
    burst   = b;
    dstaddr = dst;
    srcaddr = src;
    data    = dat;
  endtask

  // Reset asserted from time zero with non-zero inputs applied.
  task automatic test_reset();
    logic [255:0] exp_p;
    unp_t         exp_u;
    nreset = 1'b0;
    drive_fields(1'b1, 7'h33, 4'h5, 20'hABCDE, 1'b0, 64'h0102030405060708,
                 64'h1112131415161718, 256'h0A0B0C0D0E0F);
    packet_in = {8{32'hC3A5_5A3C}};
    #2;
`ifdef UMI_PACK_REG_EN
    exp_p = '0;
    exp_u = '0;
`else
    exp_p = model_pack(1'b1, 7'h33, 4'h5, 20'hABCDE, 64'h0102030405060708,
                       64'h1112131415161718, 96'h0A0B0C0D0E0F);
    exp_u = model_unpack({8{32'hC3A5_5A3C}});
`endif
    checks++;
    if (packet_out !== exp_p) begin
      errors++;
      $display("[TB] FAIL reset_packet_out: got %h expected %h", packet_out, exp_p);
    end
    checks++;
    if (dut_unp() !== exp_u) begin
      errors++;
      $display("[TB] FAIL reset_unpack: got %h expected %h", dut_unp(), exp_u);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_read_request();
    logic [255:0] exp_p;
    logic [255:0] got;
    @(negedge clk);
    drive_fields(1'b0, 7'h05, 4'h2, 20'h0, 1'b0, 64'h1122334455667788,
                 64'hAABBCCDD00000010, 256'h0);
    pack_q.push_back({32'h11223344, 32'hAABBCCDD, 96'h0, 32'h00000010,
                      32'h55667788, 20'h0, 4'h2, 8'h0A});
    step();
    exp_p = pack_q.pop_front();
    got   = packet_out;
    checks++;
    if (got !== exp_p) begin
      errors++;
      $display("[TB] FAIL read_request_packet: got %h expected %h", got, exp_p);
    end
    checks++;
    if (got[7:0] !== 8'h0A) begin
      errors++;
      $display("[TB] FAIL read_request_opcode: got %h expected 0a", got[7:0]);
    end
  endtask

  task automatic test_gpio_response();
    logic [255:0] exp_p;
    logic [255:0] got;
    @(negedge clk);
    drive_fields(1'b1, 7'h01, 4'h2, 20'h0, 1'b0, 64'h0, 64'h0, {224'b0, 32'hDEADBEEF});
    pack_q.push_back({64'h0, 64'h0, 32'hDEADBEEF, 64'h0, 20'h0, 4'h2, 8'h03});
    step();
    exp_p = pack_q.pop_front();
    got   = packet_out;
    checks++;
    if (got !== exp_p) begin
      errors++;
      $display("[TB] FAIL gpio_packet: got %h expected %h", got, exp_p);
    end
    checks++;
    if (got[127:96] !== 32'hDEADBEEF || got[0] !== 1'b1 || got[191:128] !== 64'h0) begin
      errors++;
      $display("[TB] FAIL gpio_fields: got data=%h write=%b upper=%h expected deadbeef 1 0",
               got[127:96], got[0], got[191:128]);
    end
  endtask

  task automatic test_burst();
    logic [255:0] pat;
    logic [255:0] exp_p;
    pat = {4{64'h0123456789ABCDEF}};
    @(negedge clk);
    drive_fields(1'b1, 7'h7F, 4'hF, 20'hFFFFF, 1'b1, '1, '1, pat);
    pack_q.push_back(pat);
    step();
    exp_p = pack_q.pop_front();
    checks++;
    if (packet_out !== exp_p) begin
      errors++;
      $display("[TB] FAIL burst_passthrough: got %h expected %h", packet_out, exp_p);
    end
  endtask

  task automatic test_unpack_all_ones();
    unp_t exp_u;
    unp_t got;
    @(negedge clk);
    packet_in = '1;
    unp_q.push_back({1'b1, 7'h7F, 4'hF, 20'hFFFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'hFFFF_FFFF_FFFF_FFFF, {160'b0, {96{1'b1}}}});
    step();
    exp_u = unp_q.pop_front();
    got   = dut_unp();
    checks++;
    if (got !== exp_u) begin
      errors++;
      $display("[TB] FAIL unpack_all_ones: got %h expected %h", got, exp_u);
    end
  endtask

  // New pack and unpack inputs every cycle, with burst toggling.
  task automatic test_back_to_back();
    logic [255:0] rnd;
    logic [255:0] pin;
    logic [255:0] exp_p;
    unp_t         exp_u;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive_fields(rnd[0], rnd[7:1], rnd[11:8], rnd[31:12], i[0], rnd[127:64],
                   rnd[191:128], rnd);
      packet_in = pin;
      if (i[0])
        pack_q.push_back(rnd);
      else
        pack_q.push_back(model_pack(rnd[0], rnd[7:1], rnd[11:8], rnd[31:12],
                                    rnd[127:64], rnd[191:128], rnd[95:0]));
      unp_q.push_back(model_unpack(pin));
      step();
      exp_p = pack_q.pop_front();
      exp_u = unp_q.pop_front();
      checks++;
      if (packet_out !== exp_p) begin
        errors++;
        $display("[TB] FAIL b2b_pack[%0d]: got %h expected %h", i, packet_out, exp_p);
      end
      checks++;
      if (dut_unp() !== exp_u) begin
        errors++;
        $display("[TB] FAIL b2b_unpack[%0d]: got %h expected %h", i, dut_unp(), exp_u);
      end
    end
  endtask

  // Fields -> pack -> unpack must give the fields back.
  task automatic test_round_trip();
    logic         w;
    logic [6:0]   cmd;
    logic [3:0]   sz;
    logic [19:0]  opt;
    logic [63:0]  dst;
    logic [63:0]  src;
    logic [95:0]  dat;
    logic [255:0] exp_p;
    unp_t         exp_u;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      w   = 1'($urandom);
      cmd = 7'($urandom);
      sz  = 4'($urandom);
      opt = 20'($urandom);
      dst = {$urandom, $urandom};
      src = {$urandom, $urandom};
      dat = {$urandom, $urandom, $urandom};
      drive_fields(w, cmd, sz, opt, 1'b0, dst, src, {160'b0, dat});
      pack_q.push_back(model_pack(w, cmd, sz, opt, dst, src, dat));
      step();
      exp_p = pack_q.pop_front();
      checks++;
      if (packet_out !== exp_p) begin
        errors++;
        $display("[TB] FAIL round_trip_pack[%0d]: got %h expected %h", i, packet_out, exp_p);
      end
      @(negedge clk);
      packet_in = packet_out;
      unp_q.push_back({w, cmd, sz, opt, dst, src, {160'b0, dat}});
      step();
      exp_u = unp_q.pop_front();
      checks++;
      if (dut_unp() !== exp_u) begin
        errors++;
        $display("[TB] FAIL round_trip_unpack[%0d]: got %h expected %h", i, dut_unp(), exp_u);
      end
    end
  endtask

  // Reset pulsed between clock edges with live traffic.
  task automatic test_reset_midstream();
    logic [255:0] exp_p;
    unp_t         exp_u;
    @(negedge clk);
    drive_fields(1'b1, 7'h2A, 4'h3, 20'h12345, 1'b0, 64'hCAFE0000BEEF1111,
                 64'h0000FACE00002222, 256'h55AA);
    packet_in = {8{32'h8765_4321}};
    pack_q.push_back(model_pack(1'b1, 7'h2A, 4'h3, 20'h12345, 64'hCAFE0000BEEF1111,
                                64'h0000FACE00002222, 96'h55AA));
    unp_q.push_back(model_unpack({8{32'h8765_4321}}));
    #2;
    nreset = 1'b0;
    #1;
`ifdef UMI_PACK_REG_EN
    checks++;
    if (packet_out !== '0 || dut_unp() !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_async_clear: got %h / %h expected all zero",
               packet_out, dut_unp());
    end
    step();
    checks++;
    if (packet_out !== '0 || dut_unp() !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_held_in_reset: got %h / %h expected all zero",
               packet_out, dut_unp());
    end
    @(negedge clk);
    nreset = 1'b1;
    #1;
    checks++;
    if (packet_out !== '0) begin
      errors++;
      $display("[TB] FAIL midstream_no_early_capture: got %h expected 0", packet_out);
    end
`else
    @(negedge clk);
    nreset = 1'b1;
`endif
    step();
    exp_p = pack_q.pop_front();
    exp_u = unp_q.pop_front();
    checks++;
    if (packet_out !== exp_p) begin
      errors++;
      $display("[TB] FAIL midstream_after_release_pack: got %h expected %h", packet_out, exp_p);
    end
    checks++;
    if (dut_unp() !== exp_u) begin
      errors++;
      $display("[TB] FAIL midstream_after_release_unpack: got %h expected %h", dut_unp(), exp_u);
    end
  endtask

  initial begin
    test_reset();
    test_read_request();
    test_gpio_response();
    test_burst();
    test_unpack_all_ones();
    test_back_to_back();
    test_reset_midstream();
    test_round_trip();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
